// File: rtl/text_buf_ctrl_pkg.sv
// Shared types and defaults for the text buffer write controller.
// Holds the FSM encoding, default geometry and the blank fill code.
package text_buf_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CLEAR = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_COLS   = 80;
    localparam int DEF_ROWS   = 60;
    localparam int DEF_ADDR_W = 13;

    localparam logic [7:0] BLANK = 8'h20;

endpackage

// File: rtl/text_buf_ctrl.sv
// Arbitrates terminal cell writes and full-screen clear sweeps onto the
// text buffer write port.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   req_wr, req_addr, req_data       terminal write request (held until ack)
//   req_ack                          one-cycle pulse, request consumed
//   clr_start, clr_char              clear pulse and fill code
//   clr_busy, clr_done               sweep owns buffer / sweep finished pulse
//   buf_addr, buf_data, buf_wr_en    registered buffer write port
module text_buf_ctrl
    import text_buf_ctrl_pkg::*;
#(
    parameter int COLS   = DEF_COLS,
    parameter int ROWS   = DEF_ROWS,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_data,
    output logic              req_ack,
    input  logic              clr_start,
    input  logic [7:0]        clr_char,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [7:0]        buf_data,
    output logic              buf_wr_en
);

    localparam int CELLS = COLS * ROWS;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(CELLS - 1);
    localparam logic [ADDR_W:0]   LIMIT = (ADDR_W + 1)'(CELLS);

    state_t            state, state_d;
    logic [ADDR_W-1:0] cnt, cnt_d;
    logic [7:0]        fill, fill_d;
    logic [ADDR_W-1:0] addr_d;
    logic [7:0]        data_d;
    logic              wr_d, ack_d, busy_d, done_d;
    logic              in_range;

    assign in_range = ({1'b0, req_addr} < LIMIT);

    // Outputs are registered: each is computed for the state being entered,
    // so they line up with that state's cycle.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        fill_d  = fill;
        addr_d  = buf_addr;
        data_d  = buf_data;
        wr_d    = 1'b0;
        ack_d   = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state)
            IDLE: begin
                if (clr_start) begin
                    state_d = CLEAR;
                    fill_d  = clr_char;
                    cnt_d   = '0;
                    addr_d  = '0;
                    data_d  = clr_char;
                    wr_d    = 1'b1;
                    busy_d  = 1'b1;
                end else if (req_wr) begin
                    state_d = WRITE;
                    addr_d  = req_addr;
                    data_d  = req_data;
                    ack_d   = 1'b1;
                    // Off-screen requests are acked but dropped.
                    wr_d    = in_range;
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            CLEAR: begin
                busy_d = 1'b1;
                if (cnt == LAST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d  = cnt + 1'b1;
                    addr_d = cnt + 1'b1;
                    data_d = fill;
                    wr_d   = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            fill      <= BLANK;
            buf_addr  <= '0;
            buf_data  <= '0;
            buf_wr_en <= 1'b0;
            req_ack   <= 1'b0;
            clr_busy  <= 1'b0;
            clr_done  <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            fill      <= fill_d;
            buf_addr  <= addr_d;
            buf_data  <= data_d;
            buf_wr_en <= wr_d;
            req_ack   <= ack_d;
            clr_busy  <= busy_d;
            clr_done  <= done_d;
        end
    end

endmodule

// File: tb/tb_text_buf_ctrl.sv
// Randomised and directed bench for text_buf_ctrl.
// Per-cycle compare against a queue-of-cycles model plus literal checks.
module tb_text_buf_ctrl;
    import text_buf_ctrl_pkg::*;

    localparam int N = DEF_COLS * DEF_ROWS;

    typedef struct {
        logic        wr;
        logic        ack;
        logic        busy;
        logic        done;
        logic [12:0] addr;
        logic [7:0]  data;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_wr = 1'b0;
    logic [12:0] req_addr = '0;
    logic [7:0]  req_data = '0;
    logic        clr_start = 1'b0;
    logic [7:0]  clr_char = '0;
    logic        req_ack, clr_busy, clr_done, buf_wr_en;
    logic [12:0] buf_addr;
    logic [7:0]  buf_data;

    text_buf_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_wr(req_wr), .req_addr(req_addr), .req_data(req_data),
        .req_ack(req_ack),
        .clr_start(clr_start), .clr_char(clr_char),
        .clr_busy(clr_busy), .clr_done(clr_done),
        .buf_addr(buf_addr), .buf_data(buf_data), .buf_wr_en(buf_wr_en)
    );

    always #5 clk = ~clk;

    int      n_chk = 0;
    int      n_fail = 0;
    longint  cyc = 0;
    int      n_wr = 0, n_ack = 0, n_done = 0, n_busy = 0;
    entry_t  q[$];
    entry_t  e;
    logic [7:0] ref_mem [N];
    logic [7:0] dut_mem [N];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Model: q holds the expected outputs of each upcoming cycle; an empty
    // queue means the block is idle and free to take a new command.
    always @(posedge clk) begin
        cyc++;
        if (rst_n && buf_wr_en && int'(buf_addr) < N)
            dut_mem[buf_addr] = buf_data;
        if (!rst_n) begin
            q.delete();
        end else if (q.size() != 0) begin
            e = q.pop_front();
            if (e.wr) ref_mem[e.addr] = e.data;
        end else if (clr_start) begin
            for (int i = 0; i < N; i++) begin
                e = '{wr: 1'b1, ack: 1'b0, busy: 1'b1, done: 1'b0,
                      addr: i[12:0], data: clr_char};
                q.push_back(e);
            end
            e = '{wr: 1'b0, ack: 1'b0, busy: 1'b1, done: 1'b1,
                  addr: 13'd0, data: 8'd0};
            q.push_back(e);
        end else if (req_wr) begin
            e = '{wr: (int'(req_addr) < N), ack: 1'b1, busy: 1'b0,
                  done: 1'b0, addr: req_addr, data: req_data};
            q.push_back(e);
        end
        #1;
        if (!rst_n) begin
            chk("reset_outs",
                {buf_wr_en, req_ack, clr_busy, clr_done, buf_addr, buf_data},
                '0);
        end else if (q.size() == 0) begin
            chk("idle_flags", {buf_wr_en, req_ack, clr_busy, clr_done}, '0);
        end else begin
            chk("flags", {buf_wr_en, req_ack, clr_busy, clr_done},
                {q[0].wr, q[0].ack, q[0].busy, q[0].done});
            if (q[0].wr)
                chk("write", {buf_addr, buf_data}, {q[0].addr, q[0].data});
        end
        if (buf_wr_en) n_wr++;
        if (req_ack)   n_ack++;
        if (clr_done)  n_done++;
        if (clr_busy)  n_busy++;
    end

    task automatic wait_ack(int budget);
        bit ok = 0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            if (req_ack) begin ok = 1; break; end
        end
        chk("ack_seen", 64'(ok), 64'd1);
    endtask

    task automatic wait_done(int budget);
        bit ok = 0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            if (clr_done) begin ok = 1; break; end
        end
        chk("done_seen", 64'(ok), 64'd1);
    endtask

    task automatic new_req();
        if ($urandom_range(0, 9) == 0)
            req_addr = 13'($urandom_range(N, 8191));
        else
            req_addr = 13'($urandom_range(0, N - 1));
        req_data = 8'($urandom);
        req_wr = 1'b1;
    endtask

    int s_wr, s_ack, s_done, s_busy, bad;
    longint prev;
    bit ok;

    initial begin
        for (int i = 0; i < N; i++) begin
            ref_mem[i] = 8'h00;
            dut_mem[i] = 8'h00;
        end

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_literal",
            {buf_wr_en, req_ack, clr_busy, clr_done, buf_addr, buf_data}, '0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single write addr 5 / 'A'.
        s_wr = n_wr;
        req_addr = 13'd5; req_data = 8'h41; req_wr = 1'b1;
        prev = cyc;
        wait_ack(10);
        chk("w5_latency", 64'(cyc - prev), 64'd1);
        chk("w5_port", {buf_wr_en, buf_addr, buf_data}, {1'b1, 13'd5, 8'h41});
        @(negedge clk); req_wr = 1'b0;
        repeat (5) @(negedge clk);
        chk("w5_once", 64'(n_wr - s_wr), 64'd1);

        // Full clear with blank; a mid-sweep clr_start must be ignored.
        s_wr = n_wr; s_done = n_done; s_busy = n_busy;
        clr_char = BLANK; clr_start = 1'b1;
        @(negedge clk); clr_start = 1'b0; clr_char = 8'h00;
        repeat (100) @(negedge clk);
        clr_start = 1'b1; clr_char = 8'h7e;
        @(negedge clk); clr_start = 1'b0;
        wait_done(N + 10);
        repeat (3) @(negedge clk);
        chk("clr_writes", 64'(n_wr - s_wr), 64'd4800);
        chk("clr_busy_len", 64'(n_busy - s_busy), 64'd4801);
        chk("clr_done_cnt", 64'(n_done - s_done), 64'd1);
        chk("clr_cell_0", 64'(dut_mem[0]), 64'h20);
        chk("clr_cell_4799", 64'(dut_mem[N - 1]), 64'h20);

        // Clear and write together: clear wins, write lands afterwards.
        s_done = n_done;
        clr_char = 8'h2e; clr_start = 1'b1;
        req_addr = 13'd10; req_data = 8'h58; req_wr = 1'b1;
        @(negedge clk); clr_start = 1'b0;
        wait_ack(N + 10);
        chk("ack_after_done", 64'(n_done - s_done), 64'd1);
        @(negedge clk); req_wr = 1'b0;
        repeat (2) @(negedge clk);
        chk("cell10", 64'(dut_mem[10]), 64'h58);
        chk("cell11", 64'(dut_mem[11]), 64'h2e);

        // Off-screen address is acked and dropped.
        s_wr = n_wr; s_ack = n_ack;
        req_addr = 13'd4800; req_data = 8'h33; req_wr = 1'b1;
        wait_ack(10);
        chk("oob_wr_en", 64'(buf_wr_en), 64'd0);
        @(negedge clk); req_wr = 1'b0;
        repeat (3) @(negedge clk);
        chk("oob_no_write", 64'(n_wr - s_wr), 64'd0);
        chk("oob_ack_once", 64'(n_ack - s_ack), 64'd1);

        // Reset in the middle of a sweep.
        s_done = n_done;
        clr_char = 8'h55; clr_start = 1'b1;
        @(negedge clk); clr_start = 1'b0;
        ok = 0;
        for (int k = 0; k < 2100; k++) begin
            @(posedge clk); #1;
            if (buf_wr_en && buf_addr == 13'd2000) begin ok = 1; break; end
        end
        chk("sweep_2000", 64'(ok), 64'd1);
        #1 rst_n = 1'b0;
        #1 chk("rst_mid_outs",
               {buf_wr_en, req_ack, clr_busy, clr_done, buf_addr, buf_data},
               '0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        s_wr = n_wr;
        repeat (10) @(negedge clk);
        chk("rst_no_write", 64'(n_wr - s_wr), 64'd0);
        chk("rst_no_done", 64'(n_done - s_done), 64'd0);

        // Back-to-back requests with fresh data on each ack.
        s_wr = n_wr;
        req_addr = 13'd100; req_data = 8'h80; req_wr = 1'b1;
        for (int k = 0; k < 16; k++) begin
            wait_ack(10);
            if (k > 0) chk("b2b_gap", 64'(cyc - prev), 64'd2);
            prev = cyc;
            req_addr = 13'(101 + k);
            req_data = 8'(8'h81 + k);
        end
        @(negedge clk); req_wr = 1'b0;
        repeat (3) @(negedge clk);
        chk("b2b_count", 64'(n_wr - s_wr), 64'd16);
        chk("b2b_cell_115", 64'(dut_mem[115]), 64'h8f);

        // Random traffic.
        for (int k = 0; k < 12000; k++) begin
            @(negedge clk);
            clr_start = ($urandom_range(0, 1999) == 0);
            clr_char = 8'($urandom);
            if (req_wr && req_ack) begin
                if ($urandom_range(0, 1) == 1) new_req();
                else req_wr = 1'b0;
            end else if (!req_wr && $urandom_range(0, 3) == 0) begin
                new_req();
            end
        end
        @(negedge clk);
        clr_start = 1'b0; req_wr = 1'b0;
        ok = 0;
        for (int k = 0; k < N + 20; k++) begin
            @(negedge clk);
            if (q.size() == 0) begin ok = 1; break; end
        end
        chk("drain", 64'(ok), 64'd1);
        repeat (3) @(negedge clk);

        bad = 0;
        for (int i = 0; i < N; i++)
            if (dut_mem[i] !== ref_mem[i]) bad++;
        chk("mem_image", 64'(bad), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
